pipe_hazard_ctrl: RTL

Producer side of the load-use hazard interface. The block tracks the destination descriptors {valid, is_lw, write, w_addr} of the instructions in the ID, EX and MEM stages and drives them to the hazard detector. It consumes the detector's stall request back and turns it into PC / IF-ID hold, bubble injection and flush control. A small state machine handles stall, freeze and halt, and adds a stall watchdog and performance counters.

---
 rtl/pipe_hazard_ctrl.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: tracks ID/EX/MEM destination descriptors,
// turns load-use stall requests into PC/IF-ID hold and bubble injection,
// and handles flush, freeze, halt, a stall watchdog and perf counters.
//
// state  | meaning
// RUN    | normal flow, descriptors shift every edge
// STALL  | PC and IF/ID held, bubble into EX, MEM keeps draining
// FREEZE | whole pipeline held, counters held
// HALT   | front end stopped, back end drains; left only by reset
module pipe_hazard_ctrl #(
  parameter int MAX_STALL = 4,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             new_is_lw,
  input  logic             new_write,
  input  logic [4:0]       new_w_addr,
  input  logic             new_valid,
  input  logic             stall_req,
  input  logic             flush_req,
  input  logic             freeze,
  input  logic             halt,
  output logic             is_lw_ID,
  output logic             is_lw_EX,
  output logic             is_lw_MEM,
  output logic             write_ID,
  output logic             write_EX,
  output logic             write_MEM,
  output logic [4:0]       w_addr_ID,
  output logic [4:0]       w_addr_EX,
  output logic [4:0]       w_addr_MEM,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             stall_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {RUN = 2'd0, STALL = 2'd1, FREEZE = 2'd2, HALT = 2'd3} state_t;

  typedef struct packed {
    logic       valid;
    logic       is_lw;
    logic       write;
    logic [4:0] w_addr;
  } desc_t;

  localparam desc_t BUBBLE = '0;
  // Run counter saturates one past the limit, which is where the error fires.
  localparam int RW = $clog2(MAX_STALL + 2);
  localparam logic [RW-1:0] RUN_MAX = RW'(MAX_STALL + 1);

  state_t          state_q, state_d;
  desc_t           id_q, id_d, ex_q, ex_d, mem_q, mem_d;
  logic            flush_pend_q, flush_pend_d;
  logic            stall_err_q, stall_err_d;
  logic [RW-1:0]   stall_run_q, stall_run_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  desc_t           new_desc;

  // Next-state and control outputs; priority is halt > freeze > stall > flush.
  always_comb begin
    state_d      = state_q;
    id_d         = id_q;
    ex_d         = ex_q;
    mem_d        = mem_q;
    flush_pend_d = flush_pend_q;
    stall_err_d  = stall_err_q;
    stall_run_d  = '0;
    stall_cnt_d  = stall_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    pc_en        = 1'b0;
    ifid_en      = 1'b0;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    new_desc     = '{valid: new_valid, is_lw: new_is_lw, write: new_write, w_addr: new_w_addr};

    if (halt || state_q == HALT) begin
      state_d = HALT;
      ex_d    = BUBBLE;
      mem_d   = ex_q;
    end else if (freeze) begin
      // A branch resolved while frozen must not be lost.
      state_d      = FREEZE;
      flush_pend_d = flush_pend_q | flush_req;
    end else if (stall_req) begin
      state_d      = STALL;
      idex_bubble  = 1'b1;
      ex_d         = BUBBLE;
      mem_d        = ex_q;
      flush_pend_d = flush_pend_q | flush_req;
      stall_cnt_d  = stall_cnt_q + 1'b1;
      stall_run_d  = (stall_run_q == RUN_MAX) ? stall_run_q : stall_run_q + 1'b1;
      if (stall_run_d == RUN_MAX) stall_err_d = 1'b1;
    end else begin
      state_d = RUN;
      pc_en   = 1'b1;
      ifid_en = 1'b1;
      mem_d   = ex_q;
      ex_d    = id_q;
      if (flush_req || flush_pend_q) begin
        ifid_flush   = 1'b1;
        id_d         = BUBBLE;
        flush_pend_d = 1'b0;
        flush_cnt_d  = flush_cnt_q + 1'b1;
      end else begin
        id_d = new_desc;
      end
    end
  end

  // State, descriptor and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= RUN;
      id_q         <= BUBBLE;
      ex_q         <= BUBBLE;
      mem_q        <= BUBBLE;
      flush_pend_q <= 1'b0;
      stall_err_q  <= 1'b0;
      stall_run_q  <= '0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      id_q         <= id_d;
      ex_q         <= ex_d;
      mem_q        <= mem_d;
      flush_pend_q <= flush_pend_d;
      stall_err_q  <= stall_err_d;
      stall_run_q  <= stall_run_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  // An invalid slot reports as a no-op to the hazard detector.
  assign is_lw_ID   = id_q.valid  & id_q.is_lw;
  assign is_lw_EX   = ex_q.valid  & ex_q.is_lw;
  assign is_lw_MEM  = mem_q.valid & mem_q.is_lw;
  assign write_ID   = id_q.valid  & id_q.write;
  assign write_EX   = ex_q.valid  & ex_q.write;
  assign write_MEM  = mem_q.valid & mem_q.write;
  assign w_addr_ID  = id_q.valid  ? id_q.w_addr  : 5'd0;
  assign w_addr_EX  = ex_q.valid  ? ex_q.w_addr  : 5'd0;
  assign w_addr_MEM = mem_q.valid ? mem_q.w_addr : 5'd0;

  assign stall_err = stall_err_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
  assign state_o   = state_q;

endmodule
